// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Pipeline hazard controller for a 5-stage core. It handles load-use stalls,
// taken-branch flushes and data-cache-miss freezes, and runs a stall watchdog.
// The optional feature macro HAZARD_STATS_EN adds three saturating 16-bit event
// counters: LuCnt_o, FlushCnt_o and MemStallCnt_o.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | pipeline advancing; load-use / branch actions may apply
// MEM_WAIT | data cache fill outstanding; stall cycles being counted
module hazard_stall_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] ID_Rs1_i,
  input  logic [4:0] ID_Rs2_i,
  input  logic       ID_UsesRs2_i,
  input  logic [4:0] EX_Rd_i,
  input  logic       EX_MemRead_i,
  input  logic       ID_Branch_i,
  input  logic       ID_Taken_i,
  input  logic       MEM_Stall_i,
  output logic       NoOp_o,
  output logic       PCWrite_o,
  output logic       IFIDWrite_o,
  output logic       IFFlush_o,
  output logic       PipeStall_o,
  output logic       StallTimeout_o,
  output logic       State_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] LuCnt_o,
  output logic [15:0] FlushCnt_o,
  output logic [15:0] MemStallCnt_o
`endif
);

  localparam int CNT_LOG = $clog2(TIMEOUT_CYC + 1);
  localparam int CW      = (CNT_LOG > 8) ? CNT_LOG : 8;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_stall_cnt;
  logic          r_timeout;

  logic          w_lu;
  logic          w_noop;
  logic          w_pcwrite;
  logic          w_ifidwrite;
  logic          w_flush;
  logic [CW-1:0] w_cnt_nxt;

  // Load-use detection; x0 is hard-wired zero so it never creates a dependency.
  always_comb begin
    w_lu = EX_MemRead_i && (EX_Rd_i != 5'd0) &&
           ((EX_Rd_i == ID_Rs1_i) || (ID_UsesRs2_i && (EX_Rd_i == ID_Rs2_i)));
  end

  // Hazard actions, priority: memory freeze > load-use bubble > taken-branch flush.
  always_comb begin
    w_noop      = 1'b0;
    w_pcwrite   = 1'b1;
    w_ifidwrite = 1'b1;
    w_flush     = 1'b0;
    if (MEM_Stall_i) begin
      // Registers are frozen; any bubble or flush here would corrupt them.
      w_pcwrite   = 1'b0;
      w_ifidwrite = 1'b0;
    end else if (w_lu) begin
      // A taken branch waiting behind a load-use gets flushed next cycle,
      // once LU has cleared, because ID is held in place.
      w_noop      = 1'b1;
      w_pcwrite   = 1'b0;
      w_ifidwrite = 1'b0;
    end else if (ID_Branch_i && ID_Taken_i) begin
      w_flush = 1'b1;
    end
  end

  // Next stall count: the count equals the number of consecutive stalled
  // cycles, so the entry cycle (still in RUN) counts as the first one.
  always_comb begin
    w_cnt_nxt = '0;
    if (MEM_Stall_i) begin
      if (r_state == RUN) begin
        w_cnt_nxt = (CNT_MAX == '0) ? '0 : CW'(1);
      end else if (r_stall_cnt >= CNT_MAX) begin
        w_cnt_nxt = CNT_MAX;
      end else begin
        w_cnt_nxt = r_stall_cnt + CW'(1);
      end
    end
  end

  // FSM, stall watchdog counter and sticky timeout flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (MEM_Stall_i) r_state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (!MEM_Stall_i) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
      r_stall_cnt <= w_cnt_nxt;
      if (MEM_Stall_i && (w_cnt_nxt == CNT_MAX)) r_timeout <= 1'b1;
    end
  end

  assign NoOp_o         = w_noop;
  assign PCWrite_o      = w_pcwrite;
  assign IFIDWrite_o    = w_ifidwrite;
  assign IFFlush_o      = w_flush;
  assign PipeStall_o    = MEM_Stall_i;
  assign StallTimeout_o = r_timeout;
  assign State_o        = r_state;

`ifdef HAZARD_STATS_EN
  logic [15:0] r_lu_cnt;
  logic [15:0] r_flush_cnt;
  logic [15:0] r_mstall_cnt;

  // Saturating event counters for bubbles, flushes and frozen cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lu_cnt     <= '0;
      r_flush_cnt  <= '0;
      r_mstall_cnt <= '0;
    end else begin
      if (w_noop && (r_lu_cnt != 16'hFFFF))        r_lu_cnt     <= r_lu_cnt + 16'd1;
      if (w_flush && (r_flush_cnt != 16'hFFFF))    r_flush_cnt  <= r_flush_cnt + 16'd1;
      if (MEM_Stall_i && (r_mstall_cnt != 16'hFFFF)) r_mstall_cnt <= r_mstall_cnt + 16'd1;
    end
  end

  assign LuCnt_o       = r_lu_cnt;
  assign FlushCnt_o    = r_flush_cnt;
  assign MemStallCnt_o = r_mstall_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (TIMEOUT_CYC = 8).
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       uses2, memrd, br, tk, mst;
  logic       noop, pcw, ifid, flush, pstall, tmo, state;
`ifdef HAZARD_STATS_EN
  logic [15:0] lu_cnt, fl_cnt, ms_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .ID_Rs1_i(rs1), .ID_Rs2_i(rs2), .ID_UsesRs2_i(uses2),
    .EX_Rd_i(rd), .EX_MemRead_i(memrd),
    .ID_Branch_i(br), .ID_Taken_i(tk), .MEM_Stall_i(mst),
    .NoOp_o(noop), .PCWrite_o(pcw), .IFIDWrite_o(ifid), .IFFlush_o(flush),
    .PipeStall_o(pstall), .StallTimeout_o(tmo), .State_o(state)
`ifdef HAZARD_STATS_EN
    , .LuCnt_o(lu_cnt), .FlushCnt_o(fl_cnt), .MemStallCnt_o(ms_cnt)
`endif
  );

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       uses2, memrd, br, tk, mst;
    logic       e_noop, e_pcw, e_ifid, e_flush, e_pstall;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rs1 = 0; rs2 = 0; rd = 0; uses2 = 0; memrd = 0; br = 0; tk = 0; mst = 0;
  endtask

  function automatic vec_t mk(input string n, input logic [4:0] a, input logic [4:0] b,
                              input logic u, input logic [4:0] d, input logic m,
                              input logic bb, input logic t, input logic s,
                              input logic eno, input logic epc, input logic eif,
                              input logic efl, input logic eps);
    vec_t v;
    v.name = n; v.rs1 = a; v.rs2 = b; v.uses2 = u; v.rd = d; v.memrd = m;
    v.br = bb; v.tk = t; v.mst = s;
    v.e_noop = eno; v.e_pcw = epc; v.e_ifid = eif; v.e_flush = efl; v.e_pstall = eps;
    return v;
  endfunction

  // Drive one vector, queue its expectation, compare at the falling edge.
  task automatic run_vec(input vec_t v);
    vec_t e;
    rs1 = v.rs1; rs2 = v.rs2; uses2 = v.uses2; rd = v.rd; memrd = v.memrd;
    br = v.br; tk = v.tk; mst = v.mst;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    check({e.name, ".noop"},   noop,   e.e_noop);
    check({e.name, ".pcw"},    pcw,    e.e_pcw);
    check({e.name, ".ifid"},   ifid,   e.e_ifid);
    check({e.name, ".flush"},  flush,  e.e_flush);
    check({e.name, ".pstall"}, pstall, e.e_pstall);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                name         rs1 rs2 u  rd m  br tk ms   noop pcw ifid fl ps
    vecs.push_back(mk("idle",        0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0));
    vecs.push_back(mk("lw_x5_rs1",   5, 0, 0, 5, 1, 0, 0, 0,   1, 0, 0, 0, 0));
    vecs.push_back(mk("after_lw",    5, 0, 0, 5, 0, 0, 0, 0,   0, 1, 1, 0, 0));
    vecs.push_back(mk("x0_rd",       0, 0, 0, 0, 1, 0, 0, 0,   0, 1, 1, 0, 0));
    vecs.push_back(mk("rs2_unused",  1, 5, 0, 5, 1, 0, 0, 0,   0, 1, 1, 0, 0));
    vecs.push_back(mk("rs2_used",    1, 5, 1, 5, 1, 0, 0, 0,   1, 0, 0, 0, 0));
    vecs.push_back(mk("x0_rs2",      1, 0, 1, 0, 1, 0, 0, 0,   0, 1, 1, 0, 0));
    vecs.push_back(mk("br_taken",    3, 4, 1, 7, 1, 1, 1, 0,   0, 1, 1, 1, 0));
    vecs.push_back(mk("br_not_tk",   3, 4, 1, 7, 0, 1, 0, 0,   0, 1, 1, 0, 0));
    vecs.push_back(mk("tk_no_br",    3, 4, 1, 7, 0, 0, 1, 0,   0, 1, 1, 0, 0));
    vecs.push_back(mk("br_lu_stall", 3, 9, 1, 9, 1, 1, 1, 0,   1, 0, 0, 0, 0));
    vecs.push_back(mk("br_lu_flush", 3, 9, 1, 9, 0, 1, 1, 0,   0, 1, 1, 1, 0));
    vecs.push_back(mk("mst_all",     9, 9, 1, 9, 1, 1, 1, 1,   0, 0, 0, 0, 1));
    vecs.push_back(mk("mst_plain",   0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1));
    vecs.push_back(mk("mst_release", 0, 0, 0, 0, 0, 1, 1, 0,   0, 1, 1, 1, 0));

    // Reset state
    drive_idle();
    rst = 1'b1;
    #1;
    check("rst.state", state, 0);
    check("rst.timeout", tmo, 0);
    mst = 1'b1;
    #1;
    check("rst.pstall_follows", pstall, 1);
    mst = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Memory stall with LU and taken branch held for four cycles
    drive_idle();
    step();
    rs1 = 5; rd = 5; memrd = 1; br = 1; tk = 1; mst = 1;
    #1;
    check("mst4.state_pre", state, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("mst4.state_%0d", k), state, 1);
      check($sformatf("mst4.noop_%0d", k), noop, 0);
      check($sformatf("mst4.flush_%0d", k), flush, 0);
      check($sformatf("mst4.pstall_%0d", k), pstall, 1);
    end
    drive_idle();
    step();
    check("mst4.state_end", state, 0);

    // Single-cycle stall pulse gives one round trip
    mst = 1;
    step();
    check("pulse.state_in", state, 1);
    mst = 0;
    step();
    check("pulse.state_out", state, 0);
    step();
    check("pulse.state_stay", state, 0);

    // Counter clears on return to RUN: two 5-cycle stalls must not time out
    mst = 1;
    repeat (5) step();
    mst = 0;
    step();
    mst = 1;
    repeat (5) step();
    mst = 0;
    step();
    check("clr.timeout", tmo, 0);

    // Watchdog fires after the 8th stall cycle and stays set
    mst = 1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 7) check("tmo.before", tmo, 0);
      if (k == 8) check("tmo.at8", tmo, 1);
    end
    mst = 0;
    step();
    check("tmo.sticky", tmo, 1);
    check("tmo.state_run", state, 0);
    rs1 = 5; rd = 5; memrd = 1;
    #1;
    check("tmo.lu_still_works", noop, 1);
    drive_idle();

    // Async reset mid-stall abandons the count
    mst = 1;
    repeat (3) step();
    check("arst.state_pre", state, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst.state", state, 0);
    check("arst.timeout", tmo, 0);
    check("arst.pstall", pstall, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) check("arst.first_edge", state, 1);
    end
    check("arst.cnt_restart", tmo, 0);
    step();
    check("arst.cnt_8", tmo, 1);
    mst = 0;
    step();

`ifdef HAZARD_STATS_EN
    rst = 1'b1;
    #1;
    check("stats.rst_lu", lu_cnt, 0);
    rst = 1'b0;
    drive_idle();
    step();
    for (int k = 0; k < 3; k++) begin
      rs1 = 6; rd = 6; memrd = 1;
      step();
      drive_idle();
      step();
    end
    for (int k = 0; k < 2; k++) begin
      br = 1; tk = 1;
      step();
      drive_idle();
      step();
    end
    mst = 1;
    repeat (5) step();
    mst = 0;
    step();
    check("stats.lu", lu_cnt, 3);
    check("stats.flush", fl_cnt, 2);
    check("stats.mstall", ms_cnt, 5);
    mst = 1;
    repeat (65530) step();
    check("stats.sat_reach", ms_cnt, 16'hFFFF);
    repeat (3) step();
    check("stats.sat_hold", ms_cnt, 16'hFFFF);
    mst = 0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
